// File: rtl/rgb_panel_scan_ctrl.sv
// HUB75 scan scheduler: framebuffer prefetch, column shift, latch and
// binary-coded-modulation output-enable timing for an RGB matrix panel.
module rgb_panel_scan_ctrl #(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 4,
  parameter int PLANES   = 4,
  parameter int BASE_OE  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         fb_rd_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0] fb_addr,
  input  logic [6*PLANES-1:0]          fb_data,
  output logic [5:0]                   rgbs,
  output logic [ROW_BITS-1:0]          row,
  output logic                         clk_out,
  output logic                         latch_out,
  output logic                         oe_n,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int COL_BITS = $clog2(COLS);
  localparam int PB = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int CW = (COL_BITS + 1 > 16) ? COL_BITS + 1 : 16;
  localparam int AW = ROW_BITS + COL_BITS;

  typedef enum logic [2:0] {
    IDLE, PREFETCH, SHIFT, LATCH, DISPLAY
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n, cnt_inc;
  logic [ROW_BITS-1:0] row_cnt, row_cnt_n, row_n;
  logic [PB-1:0]       plane, plane_n;
  logic                rd_q;
  logic                rd_n, clk_n, latch_n, oen_n, done_n;
  logic [AW-1:0]       addr_n;
  logic [COL_BITS-1:0] col_nx;
  logic [CW-1:0]       disp_last;

  assign cnt_inc   = cnt + CW'(1);
  assign col_nx    = cnt_inc[COL_BITS:1];
  assign disp_last = (CW'(BASE_OE) << plane) - CW'(1);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    row_cnt_n = row_cnt;
    plane_n   = plane;
    row_n     = row;
    rd_n      = 1'b0;
    addr_n    = fb_addr;
    clk_n     = 1'b0;
    latch_n   = 1'b0;
    oen_n     = 1'b1;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = PREFETCH;
          rd_n    = 1'b1;
          addr_n  = {row_cnt, COL_BITS'(0)};
        end
      end
      PREFETCH: begin
        // column 0 low phase also fetches column 1
        state_n = SHIFT;
        cnt_n   = '0;
        rd_n    = 1'b1;
        addr_n  = {row_cnt, COL_BITS'(1)};
      end
      SHIFT: begin
        if (cnt == CW'(2 * COLS - 1)) begin
          state_n = LATCH;
          latch_n = 1'b1;
          row_n   = row_cnt;
        end else begin
          cnt_n = cnt_inc;
          clk_n = cnt_inc[0];
          if (!cnt_inc[0] &&
              col_nx != COL_BITS'(COLS - 1)) begin
            rd_n   = 1'b1;
            addr_n = {row_cnt, COL_BITS'(col_nx + 1'b1)};
          end
        end
      end
      LATCH: begin
        state_n = DISPLAY;
        cnt_n   = '0;
        oen_n   = 1'b0;
      end
      DISPLAY: begin
        if (cnt == disp_last) begin
          if (plane == PB'(PLANES - 1)) begin
            plane_n   = '0;
            row_cnt_n = row_cnt + 1'b1;
            done_n    = (row_cnt == '1);
          end else begin
            plane_n = plane + 1'b1;
          end
          if (enable) begin
            state_n = PREFETCH;
            rd_n    = 1'b1;
            addr_n  = {row_cnt_n, COL_BITS'(0)};
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_inc;
          oen_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      row_cnt    <= '0;
      plane      <= '0;
      rd_q       <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
      rgbs       <= '0;
      row        <= '0;
      clk_out    <= 1'b0;
      latch_out  <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      row_cnt    <= row_cnt_n;
      plane      <= plane_n;
      rd_q       <= fb_rd_en;
      fb_rd_en   <= rd_n;
      fb_addr    <= addr_n;
      row        <= row_n;
      clk_out    <= clk_n;
      latch_out  <= latch_n;
      oe_n       <= oen_n;
      frame_done <= done_n;
      busy       <= (state_n != IDLE);
      // read data is only trusted the cycle after a strobe
      if (rd_q)
        rgbs <= fb_data[6*int'(plane) +: 6];
    end
  end

endmodule

// File: tb/tb_rgb_panel_scan_ctrl.sv
// Directed bench for rgb_panel_scan_ctrl with COLS=4, ROW_BITS=2,
// PLANES=2, BASE_OE=2 and a one-cycle-latency framebuffer model.
module tb_rgb_panel_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fb_rd_en;
  logic [3:0]  fb_addr;
  logic [11:0] fb_data;
  logic [5:0]  rgbs;
  logic [1:0]  row;
  logic        clk_out;
  logic        latch_out;
  logic        oe_n;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rgb_panel_scan_ctrl #(
    .COLS(4), .ROW_BITS(2), .PLANES(2), .BASE_OE(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
    .rgbs(rgbs), .row(row), .clk_out(clk_out),
    .latch_out(latch_out), .oe_n(oe_n),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // column c: plane0 = c, plane1 = c+8; junk when no read was issued
  always @(posedge clk) begin
    if (fb_rd_en)
      fb_data <= {6'd8 + {4'd0, fb_addr[1:0]}, {4'd0, fb_addr[1:0]}};
    else
      fb_data <= 12'hfff;
  end

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    logic [17:0] act, exp_v;
    act   = {rgbs, row, clk_out, latch_out, oe_n, fb_rd_en,
             fb_addr, frame_done, busy};
    exp_v = {6'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: outputs %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_vals("reset_state");
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fb_rd_en !== 1'b0 || oe_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: busy=%b rd=%b oe_n=%b, required 0 0 1",
               busy, fb_rd_en, oe_n);
    end
  endtask

  // one row: plane0 (12 cycles) then plane1 (14 cycles), then row1 prefetch
  task automatic test_scan();
    int o, d, col;
    logic [3:0] exp_s, act_s, exp_a;
    logic [5:0] exp_rgb;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 27; t++) begin
      @(negedge clk);
      if (t < 12) begin o = t; d = 2; end
      else if (t < 26) begin o = t - 12; d = 4; end
      else begin o = 0; d = 2; end
      exp_s[3] = (o == 0) || (o <= 5 && o % 2 == 1);
      exp_s[2] = (o >= 2 && o <= 8 && o % 2 == 0);
      exp_s[1] = (o == 9);
      exp_s[0] = !(o >= 10 && o < 10 + d);
      act_s = {fb_rd_en, clk_out, latch_out, oe_n};
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL scan_ctl t=%0d: rd/clk/lat/oe_n=%b, required %b",
                 t, act_s, exp_s);
      end
      checks++;
      if (row !== 2'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL scan_row t=%0d: row=%0d busy=%b, required 0 1",
                 t, row, busy);
      end
      checks++;
      if (!oe_n && (clk_out || latch_out)) begin
        errors++;
        $display("FAIL scan_ghost t=%0d: oe_n=0 with clk=%b latch=%b",
                 t, clk_out, latch_out);
      end
      if (exp_s[3]) begin
        col   = (o == 0) ? 0 : (o + 1) / 2;
        exp_a = 4'(((t >= 26) ? 4 : 0) + col);
        checks++;
        if (fb_addr !== exp_a) begin
          errors++;
          $display("FAIL scan_addr t=%0d: fb_addr=%0d, required %0d",
                   t, fb_addr, exp_a);
        end
      end
      if (exp_s[2]) begin
        exp_rgb = 6'(((t < 12) ? 0 : 8) + o / 2 - 1);
        checks++;
        if (rgbs !== exp_rgb) begin
          errors++;
          $display("FAIL scan_rgbs t=%0d: rgbs=%0d, required %0d",
                   t, rgbs, exp_rgb);
        end
      end
    end
  endtask

  task automatic test_frame();
    int done_cnt, done_t;
    logic [3:0] rd_q[$];
    logic [1:0] lat_q[$];
    logic [3:0] exp_a;
    logic [1:0] exp_r;
    done_cnt = 0;
    done_t   = -1;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 116; t++) begin
      @(negedge clk);
      if (fb_rd_en && t < 104) rd_q.push_back(fb_addr);
      if (latch_out) lat_q.push_back(row);
      if (frame_done) begin
        done_cnt++;
        done_t = t;
      end
    end
    checks++;
    if (done_cnt !== 1 || done_t !== 104) begin
      errors++;
      $display("FAIL frame_done: %0d pulses at t=%0d, required 1 at 104",
               done_cnt, done_t);
    end
    checks++;
    if (rd_q.size() !== 32) begin
      errors++;
      $display("FAIL frame_reads: %0d reads, required 32", rd_q.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        exp_a = 4'((i / 8) * 4 + i % 4);
        checks++;
        if (rd_q[i] !== exp_a) begin
          errors++;
          $display("FAIL frame_addr %0d: %0d, required %0d",
                   i, rd_q[i], exp_a);
        end
      end
    end
    checks++;
    if (lat_q.size() !== 9) begin
      errors++;
      $display("FAIL frame_latches: %0d, required 9", lat_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        exp_r = 2'((i / 2) % 4);
        checks++;
        if (lat_q[i] !== exp_r) begin
          errors++;
          $display("FAIL frame_row %0d: %0d, required %0d",
                   i, lat_q[i], exp_r);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int oe_lo;
    oe_lo = 0;
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 58; t++) begin
      @(negedge clk);
      if (t == 35) begin
        checks++;
        if (latch_out !== 1'b1 || row !== 2'd1) begin
          errors++;
          $display("FAIL drop_latch: latch=%b row=%0d, required 1 1",
                   latch_out, row);
        end
      end
      if (t == 36 || t == 37) begin
        checks++;
        if (oe_n !== 1'b0) begin
          errors++;
          $display("FAIL drop_disp t=%0d: oe_n=%b, required 0", t, oe_n);
        end
      end
      if (t >= 38 && t <= 42) begin
        checks++;
        if (busy !== 1'b0 || oe_n !== 1'b1 || fb_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL drop_idle t=%0d: busy=%b oe_n=%b rd=%b, required 0 1 0",
                   t, busy, oe_n, fb_rd_en);
        end
      end
      if (t == 43 || t == 57) begin
        checks++;
        if (fb_rd_en !== 1'b1 || fb_addr !== ((t == 43) ? 4'd4 : 4'd8)) begin
          errors++;
          $display("FAIL drop_resume t=%0d: rd=%b addr=%0d", t,
                   fb_rd_en, fb_addr);
        end
      end
      if (t == 45) begin
        checks++;
        if (clk_out !== 1'b1 || rgbs !== 6'd8) begin
          errors++;
          $display("FAIL drop_plane1: clk=%b rgbs=%0d, required 1 8",
                   clk_out, rgbs);
        end
      end
      if (t >= 44 && !oe_n) oe_lo++;
      if (t == 30) enable = 1'b0;
      if (t == 42) enable = 1'b1;
    end
    checks++;
    if (oe_lo !== 4) begin
      errors++;
      $display("FAIL drop_oe_len: %0d low cycles, required 4", oe_lo);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_display();
    do_reset();
    enable = 1'b1;
    for (int t = 0; t < 11; t++) @(negedge clk);
    checks++;
    if (oe_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_disp_pre: oe_n=%b, required 0", oe_n);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_disp_reset");
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if (!oe_n && (clk_out || latch_out || !busy)) begin
        errors++;
        $display("FAIL rand_ghost %0d: oe_n=0 clk=%b latch=%b busy=%b",
                 i, clk_out, latch_out, busy);
      end
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    test_reset();
    test_scan();
    test_frame();
    test_enable_drop();
    test_reset_mid_display();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
